sb_config_loader: RTL and testbench

Configuration controller for the switch-box routing fabric. It accepts a bit-serial configuration stream, assembles one 60-bit frame per switch box, and checks each frame for illegal routing before committing it. Illegal routing means multiple drivers on one pin or a bidirectional loop. Committed frames are held on a wide configuration bus that feeds each switch box's 60-bit roofconn input.

---
 rtl/sb_config_loader_pkg.sv | 34 +++
 rtl/sb_config_loader_if.sv | 28 ++
 rtl/sb_config_loader_checker.sv | 40 ++++
 rtl/sb_config_loader.sv | 131 +++++++++++++
 tb/tb_sb_config_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sb_config_loader_pkg.sv
// Shared constants and types for the switch-box configuration loader.
// Holds the frame width, the FSM state encoding, the error-code layout and
// the base offsets of the three regions in the 60-bit frame bit map.
package sb_config_loader_pkg;

  localparam int unsigned FRAME_W  = 60;
  localparam int unsigned CNT_W    = 6;             // counts 0..59 within a frame
  localparam int unsigned NUM_PIN  = 5;             // pins per switch-box side
  localparam int unsigned NUM_PAIR = FRAME_W / 2;   // forward/reverse bit pairs

  // Frame bit-map region bases: left-side links, top links, right/bottom links
  localparam int unsigned OFS_LEFT = 0;
  localparam int unsigned OFS_TOP  = 30;
  localparam int unsigned OFS_RB   = 50;

  // err_code bit positions
  localparam int unsigned ERR_CONFLICT_BIT = 0;
  localparam int unsigned ERR_LOOP_BIT     = 1;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  // Error report; field order matches ERR_LOOP_BIT / ERR_CONFLICT_BIT
  typedef struct packed {
    logic loop;
    logic conflict;
  } err_code_t;

endpackage

// File: rtl/sb_config_loader_if.sv
// Control/status bus of the configuration loader.
//   master: drives start, cfg_bit, cfg_valid; observes status and config bus
//   slave : the loader itself
interface sb_config_loader_if #(
  parameter int unsigned NUM_SB = 4,
  parameter int unsigned IDX_W  = 4
);
  logic                                         start;
  logic                                         cfg_bit;
  logic                                         cfg_valid;
  logic                                         cfg_ready;
  logic                                         busy;
  logic                                         done;
  logic                                         err;
  logic [1:0]                                   err_code;
  logic [IDX_W-1:0]                             err_frame;
  logic [NUM_SB*sb_config_loader_pkg::FRAME_W-1:0] roofconn_all;

  modport master (
    output start, cfg_bit, cfg_valid,
    input  cfg_ready, busy, done, err, err_code, err_frame, roofconn_all
  );

  modport slave (
    input  start, cfg_bit, cfg_valid,
    output cfg_ready, busy, done, err, err_code, err_frame, roofconn_all
  );
endinterface

// File: rtl/sb_config_loader_checker.sv
// Combinational legality check of one switch-box frame.
//   c        : 60-bit frame
//   conflict : some pin has more than one enabled driver
//   loop     : some forward/reverse bit pair is enabled in both directions
module sb_frame_checker
  import sb_config_loader_pkg::*;
(
  input  logic [FRAME_W-1:0] c,
  output logic               conflict,
  output logic               loop
);

  logic [NUM_PIN-1:0]  conf_left;
  logic [NUM_PIN-1:0]  conf_top;
  logic [NUM_PIN-1:0]  conf_right;
  logic [NUM_PIN-1:0]  conf_bottom;
  logic [NUM_PAIR-1:0] pair_loop;

  // True when at least two of the three drivers are on
  function automatic logic multi_drive(input logic a, input logic b, input logic d);
    return (a & b) | (a & d) | (b & d);
  endfunction

  // Driver sets per pin side
  for (genvar i = 0; i < NUM_PIN; i++) begin : g_pin
    assign conf_left[i]   = multi_drive(c[OFS_LEFT+6*i],   c[OFS_LEFT+6*i+2], c[OFS_LEFT+6*i+4]);
    assign conf_top[i]    = multi_drive(c[OFS_LEFT+6*i+1], c[OFS_TOP+4*i],    c[OFS_TOP+4*i+2]);
    assign conf_right[i]  = multi_drive(c[OFS_LEFT+6*i+3], c[OFS_TOP+4*i+1],  c[OFS_RB+2*i]);
    assign conf_bottom[i] = multi_drive(c[OFS_LEFT+6*i+5], c[OFS_TOP+4*i+3],  c[OFS_RB+2*i+1]);
  end

  // Every even/odd bit pair is a link and its reverse
  for (genvar k = 0; k < NUM_PAIR; k++) begin : g_pair
    assign pair_loop[k] = c[2*k] & c[2*k+1];
  end

  assign conflict = |{conf_left, conf_top, conf_right, conf_bottom};
  assign loop     = |pair_loop;

endmodule

// File: rtl/sb_config_loader.sv
// Switch-box configuration loader.
// Shifts in a bit-serial stream (MSB first), assembles one 60-bit frame per
// switch box, rejects frames with driver conflicts or bidirectional loops,
// and commits legal frames into the wide roofconn_all configuration bus.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : start/cfg_bit/cfg_valid in; cfg_ready, busy, done, err,
//           err_code, err_frame, roofconn_all out (all registered)
module sb_config_loader
  import sb_config_loader_pkg::*;
#(
  parameter int unsigned NUM_SB = 4,
  parameter int unsigned IDX_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  sb_config_loader_if.slave  bus
);

  localparam int unsigned ROOF_W = NUM_SB * FRAME_W;

  logic [2:0]         state;
  logic [2:0]         state_n;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   frame_idx;
  logic [FRAME_W-1:0] shadow;
  logic [ROOF_W-1:0]  roof_q;
  logic               cfg_ready_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  err_code_t          err_code_q;
  logic [IDX_W-1:0]   err_frame_q;

  logic               conflict_c;
  logic               loop_c;
  logic               last_bit_c;
  logic               last_frame_c;

  sb_frame_checker u_checker (
    .c        (shadow),
    .conflict (conflict_c),
    .loop     (loop_c)
  );

  assign last_bit_c   = bus.cfg_valid && (bit_cnt == CNT_W'(FRAME_W - 1));
  assign last_frame_c = (frame_idx == IDX_W'(NUM_SB - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (bus.start) state_n = ST_LOAD;
      ST_LOAD:                  if (last_bit_c) state_n = ST_CHECK;
      ST_CHECK:                 state_n = (conflict_c || loop_c) ? ST_ERR : ST_COMMIT;
      ST_COMMIT:                state_n = last_frame_c ? ST_DONE : ST_LOAD;
      default:                  state_n = ST_IDLE;
    endcase
  end

  // Datapath and registered status; status flags follow the next state so
  // they line up with the state register cycle for cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= '0;
      frame_idx   <= '0;
      shadow      <= '0;
      roof_q      <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      err_frame_q <= '0;
    end else begin
      cfg_ready_q <= (state_n == ST_LOAD);
      busy_q      <= (state_n == ST_LOAD) || (state_n == ST_CHECK) || (state_n == ST_COMMIT);
      done_q      <= (state_n == ST_DONE);

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            frame_idx   <= '0;
            bit_cnt     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_frame_q <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.cfg_valid) begin
            shadow  <= {shadow[FRAME_W-2:0], bus.cfg_bit};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (conflict_c || loop_c) begin
            err_q       <= 1'b1;
            err_code_q  <= '{loop: loop_c, conflict: conflict_c};
            err_frame_q <= frame_idx;
          end
        end
        ST_COMMIT: begin
          for (int unsigned k = 0; k < NUM_SB; k++) begin
            if (frame_idx == IDX_W'(k)) roof_q[k*FRAME_W +: FRAME_W] <= shadow;
          end
          if (!last_frame_c) begin
            frame_idx <= frame_idx + IDX_W'(1);
            bit_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready    = cfg_ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.err_code     = err_code_q;
  assign bus.err_frame    = err_frame_q;
  assign bus.roofconn_all = roof_q;

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed self-checking bench for sb_config_loader (NUM_SB=4).
module tb_sb_config_loader;

  localparam int unsigned NUM_SB = 4;
  localparam int unsigned IDX_W  = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;

  sb_config_loader_if #(.NUM_SB(NUM_SB), .IDX_W(IDX_W)) bus ();

  sb_config_loader #(.NUM_SB(NUM_SB), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    bus.start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_bit = 1'b0;
    reset = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Shift nbits of f (MSB first); optional 1/0 valid toggling and a start
  // pulse at bit start_at. Reports the first negedge count with cfg_ready low.
  task automatic shift_frame(input logic [59:0] f, input bit stall, input int start_at,
                             input int nbits, output int first_low);
    int cyc;
    cyc = 0; first_low = 0;
    for (int j = 0; j < nbits; j++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = f[59-j];
      bus.start     = (j == start_at);
      @(negedge clk); cyc++;
      if (!bus.cfg_ready && first_low == 0) first_low = cyc;
      bus.start = 1'b0;
      if (stall) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_bit   = ~f[59-j];
        @(negedge clk); cyc++;
        if (!bus.cfg_ready && first_low == 0) first_low = cyc;
      end
    end
    bus.cfg_valid = 1'b0;
  endtask

  // Wait until the loader asks for the next frame or leaves the busy states
  task automatic wait_settle(input string name);
    int n;
    n = 0;
    while (!(bus.cfg_ready || !bus.busy) && n < 8) begin
      @(negedge clk); n++;
    end
    tests++;
    if (n >= 8) begin fails++; $display("FAIL %s: settle timeout after %0d cycles", name, n); end
  endtask

  task automatic test_reset();
    logic [9:0] st;
    bus.start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_bit = 1'b0;
    reset = 1'b0;
    @(negedge clk); @(negedge clk);
    st = {bus.cfg_ready, bus.busy, bus.done, bus.err, bus.err_code, bus.err_frame};
    tests++; if (st !== 10'd0) begin fails++; $display("FAIL reset_status: got %b expected 0", st); end
    tests++; if (bus.roofconn_all !== '0) begin fails++; $display("FAIL reset_roof: got %h expected 0", bus.roofconn_all); end
    reset = 1'b1;
    // cfg_valid in IDLE is ignored
    for (int j = 0; j < 5; j++) begin
      bus.cfg_valid = 1'b1; bus.cfg_bit = 1'b1;
      @(negedge clk);
    end
    bus.cfg_valid = 1'b0;
    st = {bus.cfg_ready, bus.busy, bus.done, bus.err, bus.err_code, bus.err_frame};
    tests++; if (st !== 10'd0) begin fails++; $display("FAIL idle_ignore: got %b expected 0", st); end
  endtask

  task automatic test_legal();
    logic [59:0] f [4];
    int s, fl;
    f[0] = 60'h1; f[1] = 60'h8; f[2] = 60'h0; f[3] = 60'h800000000000000;
    do_reset();
    s = edge_cnt;
    pulse_start();
    tests++; if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL first_ready: got %b expected 1", bus.cfg_ready); end
    for (int k = 0; k < 4; k++) begin
      shift_frame(f[k], 1'b0, -1, 60, fl);
      if (k == 0) begin
        tests++; if (fl !== 60) begin fails++; $display("FAIL ready_drop: got %0d expected 60", fl); end
      end
      wait_settle("legal_frame");
    end
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL legal_done: got %b expected 1", bus.done); end
    tests++; if (edge_cnt - s !== 249) begin fails++; $display("FAIL legal_latency: got %0d expected 249", edge_cnt - s); end
    tests++; if ({bus.err, bus.busy, bus.cfg_ready} !== 3'b000) begin fails++; $display("FAIL legal_flags: got %b expected 000", {bus.err, bus.busy, bus.cfg_ready}); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (bus.roofconn_all[k*60 +: 60] !== f[k]) begin
        fails++; $display("FAIL legal_slice%0d: got %h expected %h", k, bus.roofconn_all[k*60 +: 60], f[k]);
      end
    end
    repeat (3) @(negedge clk);
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL done_hold: got %b expected 1", bus.done); end
    pulse_start();
    tests++; if ({bus.done, bus.cfg_ready} !== 2'b01) begin fails++; $display("FAIL done_restart: got %b expected 01", {bus.done, bus.cfg_ready}); end
  endtask

  task automatic test_loop();
    int fl;
    do_reset();
    pulse_start();
    shift_frame(60'h3, 1'b0, -1, 60, fl);
    wait_settle("loop_frame");
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL loop_err: got %b expected 1", bus.err); end
    tests++; if (bus.err_code !== 2'b10) begin fails++; $display("FAIL loop_code: got %b expected 10", bus.err_code); end
    tests++; if (bus.err_frame !== 4'd0) begin fails++; $display("FAIL loop_frame: got %0d expected 0", bus.err_frame); end
    // cfg_valid in ERR is ignored and the error is sticky
    for (int j = 0; j < 4; j++) begin
      bus.cfg_valid = 1'b1; bus.cfg_bit = 1'b1;
      @(negedge clk);
    end
    bus.cfg_valid = 1'b0;
    tests++; if ({bus.err, bus.err_code, bus.cfg_ready, bus.done} !== 5'b11000) begin
      fails++; $display("FAIL loop_sticky: got %b expected 11000", {bus.err, bus.err_code, bus.cfg_ready, bus.done});
    end
    tests++; if (bus.roofconn_all !== '0) begin fails++; $display("FAIL loop_roof: got %h expected 0", bus.roofconn_all); end
  endtask

  task automatic test_restart_err();
    int fl;
    pulse_start();
    tests++; if ({bus.err, bus.err_code, bus.cfg_ready} !== 4'b0001) begin
      fails++; $display("FAIL restart_clear: got %b expected 0001", {bus.err, bus.err_code, bus.cfg_ready});
    end
    shift_frame(60'h2, 1'b0, -1, 60, fl);
    wait_settle("restart_frame");
    tests++; if (bus.roofconn_all[59:0] !== 60'h2) begin fails++; $display("FAIL restart_slice0: got %h expected 2", bus.roofconn_all[59:0]); end
    tests++; if ({bus.err, bus.cfg_ready} !== 2'b01) begin fails++; $display("FAIL restart_flags: got %b expected 01", {bus.err, bus.cfg_ready}); end
  endtask

  task automatic test_conflict();
    logic [239:0] exp_roof;
    int fl;
    exp_roof = '0;
    exp_roof[59:0] = 60'h800000040000009;
    do_reset();
    pulse_start();
    shift_frame(60'h800000040000009, 1'b0, -1, 60, fl);
    wait_settle("conflict_f0");
    shift_frame(60'h5, 1'b0, -1, 60, fl);
    wait_settle("conflict_f1");
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL conflict_err: got %b expected 1", bus.err); end
    tests++; if (bus.err_code !== 2'b01) begin fails++; $display("FAIL conflict_code: got %b expected 01", bus.err_code); end
    tests++; if (bus.err_frame !== 4'd1) begin fails++; $display("FAIL conflict_frame: got %0d expected 1", bus.err_frame); end
    tests++; if (bus.roofconn_all !== exp_roof) begin fails++; $display("FAIL conflict_roof: got %h expected %h", bus.roofconn_all, exp_roof); end
  endtask

  task automatic test_stall();
    int fl;
    do_reset();
    pulse_start();
    shift_frame(60'h400000020000012, 1'b1, -1, 60, fl);
    tests++; if (fl !== 119) begin fails++; $display("FAIL stall_check_time: got %0d expected 119", fl); end
    wait_settle("stall_frame");
    tests++; if (bus.roofconn_all[59:0] !== 60'h400000020000012) begin
      fails++; $display("FAIL stall_slice0: got %h expected 400000020000012", bus.roofconn_all[59:0]);
    end
    tests++; if ({bus.err, bus.cfg_ready} !== 2'b01) begin fails++; $display("FAIL stall_flags: got %b expected 01", {bus.err, bus.cfg_ready}); end
  endtask

  task automatic test_midop();
    logic [59:0] m [4];
    logic [9:0]  st;
    int fl;
    m[0] = 60'h400000020000012; m[1] = 60'h800000040000009; m[2] = 60'h8; m[3] = 60'h1;
    do_reset();
    pulse_start();
    shift_frame(m[0], 1'b0, 10, 60, fl);   // start mid-LOAD must be ignored
    wait_settle("midop_f0");
    shift_frame(m[1], 1'b0, -1, 60, fl);
    wait_settle("midop_f1");
    tests++; if (bus.roofconn_all[119:0] !== {m[1], m[0]}) begin
      fails++; $display("FAIL midop_slices: got %h expected %h", bus.roofconn_all[119:0], {m[1], m[0]});
    end
    shift_frame(m[2], 1'b0, -1, 30, fl);
    #2 reset = 1'b0;
    #1;
    st = {bus.cfg_ready, bus.busy, bus.done, bus.err, bus.err_code, bus.err_frame};
    tests++; if (st !== 10'd0) begin fails++; $display("FAIL midop_reset_status: got %b expected 0", st); end
    tests++; if (bus.roofconn_all !== '0) begin fails++; $display("FAIL midop_reset_roof: got %h expected 0", bus.roofconn_all); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      shift_frame(m[k], 1'b0, -1, 60, fl);
      wait_settle("midop_reload");
    end
    tests++; if ({bus.done, bus.err} !== 2'b10) begin fails++; $display("FAIL midop_done: got %b expected 10", {bus.done, bus.err}); end
    tests++; if (bus.roofconn_all !== {m[3], m[2], m[1], m[0]}) begin
      fails++; $display("FAIL midop_reload_roof: got %h expected %h", bus.roofconn_all, {m[3], m[2], m[1], m[0]});
    end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_loop();
    test_restart_err();
    test_conflict();
    test_stall();
    test_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
